// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage sequencer in front of a word-addressed memory with registered reads.
// Adds byte/half loads with extension and byte/half stores by read-modify-write.
module load_store_unit #(
   parameter int WORD_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [5:0]           req_opcode,
   input  logic [WORD_SIZE-1:0] req_addr,
   input  logic [WORD_SIZE-1:0] req_wdata,
   output logic                 resp_valid,
   output logic [WORD_SIZE-1:0] resp_rdata,
   output logic                 resp_err,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic [5:0]           mem_opcode,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata
);
   localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24,
                          OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

   typedef enum logic [2:0] {IDLE, LD_REQ, LD_CAP, ST_W, RMW_REQ, RMW_CAP, RMW_WR, RESP} state_t;

   state_t               state_q, state_d;
   logic                 mem_read_q, mem_read_d, mem_write_q, mem_write_d;
   logic                 resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
   logic [5:0]           mem_opcode_q, mem_opcode_d;
   logic [1:0]           lane_q, lane_d;
   logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [WORD_SIZE-1:0] resp_rdata_q, resp_rdata_d;
   logic                 is_ld, is_st, is_half, is_word, req_err, accept;
   logic [4:0]           lane_sh;
   logic [WORD_SIZE-1:0] rd_sh, mask, ext;

   assign is_ld   = req_opcode inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
   assign is_st   = req_opcode inside {OP_SB, OP_SH, OP_SW};
   assign is_half = req_opcode inside {OP_LH, OP_LHU, OP_SH};
   assign is_word = req_opcode inside {OP_LW, OP_SW};
   assign req_err = !(is_ld || is_st) || (is_half && req_addr[0]) || (is_word && |req_addr[1:0]);
   assign accept  = (state_q == IDLE) && req_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         mem_opcode_q <= '0;
         lane_q       <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         mem_opcode_q <= mem_opcode_d;
         lane_q       <= lane_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = req_err ? RESP : is_ld ? LD_REQ :
                                           (req_opcode == OP_SW) ? ST_W : RMW_REQ;
         LD_REQ:  state_d = LD_CAP;
         LD_CAP:  state_d = RESP;
         ST_W:    state_d = RESP;
         RMW_REQ: state_d = RMW_CAP;
         RMW_CAP: state_d = RMW_WR;
         RMW_WR:  state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_comb begin
      lane_sh      = {lane_q, 3'b000};
      rd_sh        = mem_rdata >> lane_sh;
      mask         = ((mem_opcode_q == OP_SB) ? WORD_SIZE'(8'hFF) : WORD_SIZE'(16'hFFFF)) << lane_sh;
      ext          = (mem_opcode_q == OP_LB)  ? {{(WORD_SIZE-8){rd_sh[7]}}, rd_sh[7:0]} :
                     (mem_opcode_q == OP_LBU) ? {{(WORD_SIZE-8){1'b0}}, rd_sh[7:0]} :
                     (mem_opcode_q == OP_LH)  ? {{(WORD_SIZE-16){rd_sh[15]}}, rd_sh[15:0]} :
                     (mem_opcode_q == OP_LHU) ? {{(WORD_SIZE-16){1'b0}}, rd_sh[15:0]} : mem_rdata;
      mem_read_d   = state_d inside {LD_REQ, LD_CAP, RMW_REQ, RMW_CAP};
      mem_write_d  = state_d inside {ST_W, RMW_WR};
      resp_valid_d = state_d == RESP;
      resp_err_d   = accept && req_err;
      resp_rdata_d = (state_q == LD_CAP) ? ext : '0;
      mem_opcode_d = accept ? req_opcode : mem_opcode_q;
      lane_d       = accept ? req_addr[1:0] : lane_q;
      mem_addr_d   = accept ? {2'b00, req_addr[WORD_SIZE-1:2]} : mem_addr_q;
      // Store data rides in mem_wdata until the old word arrives and the lane is merged in.
      mem_wdata_d  = accept ? req_wdata :
                     (state_q == RMW_CAP) ? ((mem_rdata & ~mask) | ((mem_wdata_q << lane_sh) & mask)) :
                     mem_wdata_q;
   end

   assign req_ready  = state_q == IDLE;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign MemRead    = mem_read_q;
   assign MemWrite   = mem_write_q;
   assign mem_opcode = mem_opcode_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table, reset/back-to-back sequences and random traffic
// checked against a byte-array memory model.
module tb_load_store_unit;
   logic        clk = 1'b0, rst_n = 1'b0, mem_clr = 1'b1;
   logic        req_valid = 1'b0, req_ready, resp_valid, resp_err, MemRead, MemWrite;
   logic [5:0]  req_opcode = '0, mem_opcode;
   logic [31:0] req_addr = '0, req_wdata = '0, resp_rdata, mem_addr, mem_wdata, mem_rdata, rd_q;
   logic [31:0] mem_w [0:63];
   logic [7:0]  ref_b [0:255];
   int          tests = 0, fails = 0;

   always #5 clk = ~clk;

   load_store_unit #(.WORD_SIZE(32)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .MemRead(MemRead), .MemWrite(MemWrite), .mem_opcode(mem_opcode),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Memory with a registered read that clears to 0 when not reading.
   always @(posedge clk) begin
      if (mem_clr) for (int i = 0; i < 64; i++) mem_w[i] <= '0;
      else if (MemWrite) mem_w[mem_addr[5:0]] <= mem_wdata;
      rd_q <= MemRead ? mem_w[mem_addr[5:0]] : '0;
   end
   assign mem_rdata = rd_q;

   typedef struct {
      logic [5:0] op; logic [31:0] addr, wd, rd; logic err; int lat, nr, nw, wpos;
   } vec_t;
   vec_t vt [15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: byte-addressed memory; size/sign from the opcode, alignment by modulo.
   task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] r, output logic e, output int lat);
      int sz; bit ld, sgn; longint v;
      sz = 0; ld = 0; sgn = 0; v = 0; r = '0;
      case (op)
         6'h20: begin sz = 1; ld = 1; sgn = 1; end
         6'h21: begin sz = 2; ld = 1; sgn = 1; end
         6'h23: begin sz = 4; ld = 1; end
         6'h24: begin sz = 1; ld = 1; end
         6'h25: begin sz = 2; ld = 1; end
         6'h28: sz = 1;
         6'h29: sz = 2;
         6'h2B: sz = 4;
         default: sz = 0;
      endcase
      e = (sz == 0) || (a % sz != 0);
      if (e) lat = 1;
      else if (ld) begin
         for (int i = 0; i < sz; i++) v = v + (longint'(ref_b[a + i]) << (8 * i));
         if (sgn && v[8 * sz - 1]) v = v - (longint'(1) << (8 * sz));
         r = v[31:0];
         lat = 3;
      end else begin
         for (int i = 0; i < sz; i++) ref_b[a + i] = 8'(wd >> (8 * i));
         lat = (sz == 4) ? 2 : 4;
      end
   endtask

   task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e, output int lat, output int nr,
                      output int nw, output int wpos, output logic ok);
      int n;
      rd = '0; e = 1'b0; lat = 0; nr = 0; nw = 0; wpos = 0; ok = 1'b1;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_opcode = op; req_addr = a; req_wdata = wd;
      @(posedge clk);
      for (n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (n == 1) req_valid = 1'b0;
         if (MemRead) nr++;
         if (MemWrite) begin nw++; wpos = n; end
         if ((MemRead && MemWrite) || req_ready) ok = 1'b0;
         if ((MemRead || MemWrite) && mem_addr != (a >> 2)) ok = 1'b0;
         if (resp_valid) begin rd = resp_rdata; e = resp_err; lat = n; break; end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, mr, last;
      logic e, me, ok;
      int lat, ml, nr, nw, wpos, acc, nresp;
      logic [5:0] ops [9];
      for (int i = 0; i < 256; i++) ref_b[i] = '0;
      vt[0]  = '{6'h2B, 32'h10, 32'h8081_7F01, 32'h0,         1'b0, 2, 0, 1, 1};
      vt[1]  = '{6'h23, 32'h10, 32'h0,         32'h8081_7F01, 1'b0, 3, 2, 0, 0};
      vt[2]  = '{6'h20, 32'h13, 32'h0,         32'hFFFF_FF80, 1'b0, 3, 2, 0, 0};
      vt[3]  = '{6'h24, 32'h13, 32'h0,         32'h0000_0080, 1'b0, 3, 2, 0, 0};
      vt[4]  = '{6'h21, 32'h12, 32'h0,         32'hFFFF_8081, 1'b0, 3, 2, 0, 0};
      vt[5]  = '{6'h25, 32'h10, 32'h0,         32'h0000_7F01, 1'b0, 3, 2, 0, 0};
      vt[6]  = '{6'h20, 32'h10, 32'h0,         32'h0000_0001, 1'b0, 3, 2, 0, 0};
      vt[7]  = '{6'h28, 32'h11, 32'hFFFF_FFAA, 32'h0,         1'b0, 4, 2, 1, 3};
      vt[8]  = '{6'h23, 32'h10, 32'h0,         32'h8081_AA01, 1'b0, 3, 2, 0, 0};
      vt[9]  = '{6'h29, 32'h12, 32'hABCD_1234, 32'h0,         1'b0, 4, 2, 1, 3};
      vt[10] = '{6'h23, 32'h10, 32'h0,         32'h1234_AA01, 1'b0, 3, 2, 0, 0};
      vt[11] = '{6'h23, 32'h12, 32'h5,         32'h0,         1'b1, 1, 0, 0, 0};
      vt[12] = '{6'h29, 32'h11, 32'h5,         32'h0,         1'b1, 1, 0, 0, 0};
      vt[13] = '{6'h3F, 32'h10, 32'h5,         32'h0,         1'b1, 1, 0, 0, 0};
      vt[14] = '{6'h23, 32'h10, 32'h0,         32'h1234_AA01, 1'b0, 3, 2, 0, 0};

      repeat (3) @(negedge clk);
      chk("reset ctl", {27'b0, MemRead, MemWrite, resp_valid, resp_err, req_ready}, 32'h1);
      chk("reset bus", mem_addr | mem_wdata | resp_rdata | {26'b0, mem_opcode}, 32'h0);
      rst_n = 1'b1; mem_clr = 1'b0;

      foreach (vt[i]) begin
         model(vt[i].op, vt[i].addr, vt[i].wd, mr, me, ml);
         run(vt[i].op, vt[i].addr, vt[i].wd, rd, e, lat, nr, nw, wpos, ok);
         chk($sformatf("v%0d rdata", i), rd, vt[i].rd);
         chk($sformatf("v%0d err", i), {31'b0, e}, {31'b0, vt[i].err});
         chk($sformatf("v%0d latency", i), lat, vt[i].lat);
         chk($sformatf("v%0d reads", i), nr, vt[i].nr);
         chk($sformatf("v%0d writes", i), nw, vt[i].nw);
         chk($sformatf("v%0d write cycle", i), wpos, vt[i].wpos);
         chk($sformatf("v%0d protocol", i), {31'b0, ok}, 32'h1);
      end

      // Reset asserted while an sb sits in RMW_CAP: nothing may be written.
      @(negedge clk);
      req_valid = 1'b1; req_opcode = 6'h28; req_addr = 32'h10; req_wdata = 32'h55;
      @(posedge clk);
      @(negedge clk) req_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst ctl", {27'b0, MemRead, MemWrite, resp_valid, resp_err, req_ready}, 32'h1);
      chk("midrst bus", mem_addr | mem_wdata | resp_rdata | {26'b0, mem_opcode}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model(6'h23, 32'h10, 32'h0, mr, me, ml);
      run(6'h23, 32'h10, 32'h0, rd, e, lat, nr, nw, wpos, ok);
      chk("midrst word", rd, 32'h1234_AA01);
      chk("midrst model", rd, mr);
      chk("midrst latency", lat, 3);

      // sw then lw held on req_valid while busy.
      @(negedge clk);
      req_valid = 1'b1; req_opcode = 6'h2B; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
      model(6'h2B, 32'h20, 32'hDEAD_BEEF, mr, me, ml);
      acc = 1; nr = 0; nw = 0; nresp = 0; last = '0;
      @(posedge clk);
      @(negedge clk);
      req_opcode = 6'h23; req_wdata = '0;
      for (int k = 0; k < 20 && nresp < 2; k++) begin
         if (acc == 2) req_valid = 1'b0;
         if (MemRead) nr++;
         if (MemWrite) nw++;
         if (resp_valid) begin nresp++; last = resp_rdata; end
         if (req_valid && req_ready) acc++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("b2b accepts", acc, 2);
      chk("b2b responses", nresp, 2);
      chk("b2b reads", nr, 2);
      chk("b2b writes", nw, 1);
      chk("b2b rdata", last, 32'hDEAD_BEEF);

      ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00};
      for (int t = 0; t < 300; t++) begin
         logic [5:0] op;
         logic [31:0] a, wd;
         op = ops[$urandom_range(0, 8)];
         if (op == 6'h00) op = 6'($urandom);
         a = $urandom_range(0, 255);
         wd = $urandom;
         model(op, a, wd, mr, me, ml);
         run(op, a, wd, rd, e, lat, nr, nw, wpos, ok);
         chk($sformatf("rnd%0d op%h a%h rdata", t, op, a), rd, mr);
         chk($sformatf("rnd%0d err", t), {31'b0, e}, {31'b0, me});
         chk($sformatf("rnd%0d latency", t), lat, ml);
         chk($sformatf("rnd%0d protocol", t), {31'b0, ok}, 32'h1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
